frac_digit_sequencer: RTL and testbench
=======================================

// Module: frac_digit_sequencer
// PURPOSE
//  Iterative controller converting an unsigned binary fraction (0.f) to NDIG decimal digits.
//  Computes one multiply-by-10 step per clock, buffers the digits, then streams them out
//  over a valid/ready handshake. Sits between the CORDIC result path and the display/PS2 UI.
// PARAMETERS
//  WIDTH_F  15  fraction width in bits (value = i_frac / 2^WIDTH_F)
//  NDIG      7  decimal digits produced, 1..15
//  IDXW      4  width of o_dig_idx (>= clog2(NDIG))
// PORTS
//  iCLK         in   1          clock, rising edge
//  iRST_N       in   1          asynchronous reset, active-low
//  i_start      in   1          start request; sampled only in IDLE
//  i_frac       in   WIDTH_F    fraction operand, captured on accepted start
//  o_busy       out  1          high from accepted start until the final digit handshake
//  o_dig_valid  out  1          streamed digit valid
//  i_dig_ready  in   1          sink ready; transfer = o_dig_valid & i_dig_ready
//  o_dig        out  4          BCD digit, most significant (tenths) first
//  o_dig_idx    out  IDXW       index of o_dig, 0 = tenths
//  o_last       out  1          high with the digit at index NDIG-1
//  o_digits     out  4*NDIG     all digits, digit 0 in MSB nibble; held until next start
//  o_done       out  1          one-cycle pulse after final transfer
//  o_carry      out  1          rounding carried into the integer part (0 without ROUND_EN)
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; internal fraction, counter and digit buffer cleared.
//  FSM IDLE -> CONV -> [ROUND] -> EMIT -> IDLE.
//  IDLE: i_start=1 captures i_frac, clears buffer/o_carry, sets o_busy, goes to CONV.
//    i_start is ignored in all other states (no queuing).
//  CONV: per cycle z = f*10 (WIDTH_F+4 bits); digit = z[WIDTH_F+3:WIDTH_F];
//    f <= z[WIDTH_F-1:0]; digit written to buffer slot k, k++.
//    Duration NDIG cycles (NDIG+1 with ROUND_EN; last step yields the guard digit only).
//  EMIT: o_dig_valid=1, o_dig=buf[idx]. Digit/idx/last stay stable while ready=0.
//    Transfer at idx<NDIG-1 advances idx next cycle; transfer at NDIG-1 -> IDLE,
//    o_busy=0 and o_done=1 for exactly that next cycle. A start in that o_done cycle is accepted.
//  Min latency start -> first valid: NDIG+1 cycles (NDIG+3 with ROUND_EN).
//  i_frac=0 yields all-zero digits; no early exit on zero remainder.
//  Reset mid-operation aborts immediately; no partial o_done.
// CONFIGURATION
//  Macro FRAC_ROUND_EN:
//   Defined: guard digit computed; ROUND state (1 cycle) adds 1 at digit NDIG-1 if guard>=5,
//    rippling BCD carries (9->0, +1 to next higher) through the buffer in that cycle.
//    Carry out of digit 0 sets o_carry=1 (buffer wraps to all zeros). Held until next start.
//   Undefined: no guard step, no ROUND state, digits truncated, o_carry tied 0.
// TESTING
//  1 reset, i_frac=15'h4000 start -> stream 5,0,0,0,0,0,0; o_last on idx 6; o_done 1 cycle.
//  2 i_frac=15'h7FFF, no ROUND -> 9,9,9,9,6,9,4; with FRAC_ROUND_EN -> 9,9,9,9,6,9,5, o_carry=0.
//  3 FRAC_ROUND_EN, NDIG=4, i_frac=15'h7FFF -> guard 6, digits 0,0,0,0, o_carry=1.
//  4 i_frac=15'h0001, ready held low 3 cycles at idx 4 -> o_dig=3, idx=4 stable; stream 0,0,0,0,3,0,5.
//  5 i_start pulsed in CONV and EMIT -> ignored, stream unchanged; start in o_done cycle -> new run.
//  6 iRST_N low during EMIT idx 2 -> all outputs 0 asynchronously, IDLE, no o_done after release.

Source files
------------

// File: rtl/frac_digit_sequencer.sv
// -----------------------------------------------------------------------------
// frac_digit_sequencer
//
// Converts an unsigned binary fraction 0.f (f = i_frac / 2^WIDTH_F) into NDIG
// BCD digits, one multiply-by-10 step per clock. The digits are buffered and
// then streamed out most significant (tenths) first over a valid/ready
// handshake. The full digit vector stays on o_digits until the next start.
//
// Optional feature (macro FRAC_ROUND_EN):
//   defined   - one extra guard-digit step plus a one-cycle ROUND state that
//               rounds half-up at digit NDIG-1, rippling BCD carries through
//               the buffer; a carry out of the tenths digit sets o_carry.
//   undefined - digits are truncated and o_carry is tied low.
//
// Ports
//   iCLK, iRST_N  clock (rising edge), asynchronous active-low reset
//   i_start       start request, only honoured in IDLE
//   i_frac        fraction operand, captured on an accepted start
//   o_busy        high from accepted start until the final digit transfer
//   o_dig_valid   streamed digit valid
//   i_dig_ready   sink ready; a transfer is o_dig_valid & i_dig_ready
//   o_dig         current BCD digit
//   o_dig_idx     index of o_dig, 0 = tenths
//   o_last        high with the digit at index NDIG-1
//   o_digits      all digits, digit 0 in the MSB nibble
//   o_done        one-cycle pulse after the final transfer
//   o_carry       rounding carried into the integer part
// -----------------------------------------------------------------------------
module frac_digit_sequencer #(
  parameter int WIDTH_F = 15,
  parameter int NDIG    = 7,
  parameter int IDXW    = 4
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic                i_start,
  input  logic [WIDTH_F-1:0]  i_frac,
  output logic                o_busy,
  output logic                o_dig_valid,
  input  logic                i_dig_ready,
  output logic [3:0]          o_dig,
  output logic [IDXW-1:0]     o_dig_idx,
  output logic                o_last,
  output logic [4*NDIG-1:0]   o_digits,
  output logic                o_done,
  output logic                o_carry
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;
`ifdef FRAC_ROUND_EN
  localparam logic [1:0] S_ROUND = 2'd3;
  localparam int         NSTEP   = NDIG + 1;  // last step yields the guard digit
`else
  localparam int         NSTEP   = NDIG;
`endif

  // Step counter must reach NDIG (guard step), which o_dig_idx need not hold.
  localparam int              KW       = $clog2(NDIG + 2);
  localparam logic [KW-1:0]   K_LAST   = KW'(NSTEP - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);

  logic [1:0]         r_state;
  logic [WIDTH_F-1:0] r_frac;
  logic [KW-1:0]      r_k;
  logic [IDXW-1:0]    r_idx;
  logic               r_done;
  logic [3:0]         r_dig [NDIG];

  logic [WIDTH_F+3:0] w_z;
  logic [3:0]         w_zdig;
  logic [3:0]         w_dig;
  logic [4*NDIG-1:0]  w_digits;

  // One decimal step: the integer part of f*10 is the next digit, the
  // fractional part is the remainder carried to the following step.
  assign w_z    = {4'd0, r_frac} * (WIDTH_F + 4)'(10);
  assign w_zdig = w_z[WIDTH_F+3:WIDTH_F];

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise unassigned paths infer latches.
  always_comb begin
    w_dig = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (r_idx == IDXW'(i)) w_dig = r_dig[i];
    end
  end

  always_comb begin
    w_digits = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_digits[4*(NDIG-1-i) +: 4] = r_dig[i];
    end
  end

`ifdef FRAC_ROUND_EN
  logic [3:0] r_guard;
  logic       r_carry;
  logic [3:0] w_rnd [NDIG];
  logic       w_rnd_carry;

  // Buffer plus one at digit NDIG-1 with a full BCD ripple toward digit 0.
  always_comb begin
    w_rnd_carry = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      w_rnd[i] = r_dig[i];
      if (w_rnd_carry) begin
        if (r_dig[i] == 4'd9) begin
          w_rnd[i] = 4'd0;
        end else begin
          w_rnd[i]    = r_dig[i] + 4'd1;
          w_rnd_carry = 1'b0;
        end
      end
    end
  end

  assign o_carry = r_carry;
`else
  assign o_carry = 1'b0;
`endif

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the digit buffer is small and must read zero after
  // reset, so it is reset along with the control state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_frac  <= '0;
      r_k     <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
      for (int i = 0; i < NDIG; i++) r_dig[i] <= 4'd0;
`ifdef FRAC_ROUND_EN
      r_guard <= 4'd0;
      r_carry <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_frac  <= i_frac;
            r_k     <= '0;
            r_idx   <= '0;
            for (int i = 0; i < NDIG; i++) r_dig[i] <= 4'd0;
`ifdef FRAC_ROUND_EN
            r_carry <= 1'b0;
`endif
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_frac <= w_z[WIDTH_F-1:0];
          for (int i = 0; i < NDIG; i++) begin
            if (r_k == KW'(i)) r_dig[i] <= w_zdig;
          end
`ifdef FRAC_ROUND_EN
          if (r_k == KW'(NDIG)) r_guard <= w_zdig;
`endif
          r_k <= r_k + KW'(1);
          if (r_k == K_LAST) begin
`ifdef FRAC_ROUND_EN
            r_state <= S_ROUND;
`else
            r_state <= S_EMIT;
`endif
          end
        end
`ifdef FRAC_ROUND_EN
        S_ROUND: begin
          if (r_guard >= 4'd5) begin
            for (int i = 0; i < NDIG; i++) r_dig[i] <= w_rnd[i];
            r_carry <= w_rnd_carry;
          end
          r_state <= S_EMIT;
        end
`endif
        S_EMIT: begin
          if (i_dig_ready) begin
            if (r_idx == IDX_LAST) begin
              r_idx   <= '0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + IDXW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_dig_valid = (r_state == S_EMIT);
  assign o_dig       = w_dig;
  assign o_dig_idx   = r_idx;
  assign o_last      = (r_state == S_EMIT) && (r_idx == IDX_LAST);
  assign o_digits    = w_digits;
  assign o_done      = r_done;

endmodule

// File: tb/tb_frac_digit_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frac_digit_sequencer
//
// Directed bench for frac_digit_sequencer. A 7-digit instance covers the
// stream, handshake stalls, ignored starts, back-to-back start and async
// reset; a 4-digit instance covers the all-nines rounding wrap. Expected
// digits are hand-computed; FRAC_ROUND_EN selects the rounded variants.
// -----------------------------------------------------------------------------
module tb_frac_digit_sequencer;

  localparam int NDIG = 7;
  localparam int WF   = 15;
  localparam int IDXW = 4;

`ifdef FRAC_ROUND_EN
  localparam logic [27:0] EXP_MAX  = 28'h9999695;  // 0.99996948.. rounded
  localparam int          LAT      = NDIG + 2;
  localparam logic [15:0] EXP_S    = 16'h0000;     // 0.9999|6 rounds to 1.0000
  localparam logic        EXP_S_CY = 1'b1;
`else
  localparam logic [27:0] EXP_MAX  = 28'h9999694;  // truncated
  localparam int          LAT      = NDIG;
  localparam logic [15:0] EXP_S    = 16'h9999;
  localparam logic        EXP_S_CY = 1'b0;
`endif

  logic              iCLK = 1'b0;
  logic              iRST_N = 1'b0;
  logic              i_start = 1'b0;
  logic [WF-1:0]     i_frac = '0;
  logic              i_dig_ready = 1'b0;
  logic              o_busy, o_dig_valid, o_last, o_done, o_carry;
  logic [3:0]        o_dig;
  logic [IDXW-1:0]   o_dig_idx;
  logic [4*NDIG-1:0] o_digits;

  logic              s_start = 1'b0;
  logic [WF-1:0]     s_frac = '0;
  logic              s_busy, s_valid, s_last, s_done, s_carry;
  logic [3:0]        s_dig;
  logic [IDXW-1:0]   s_idx;
  logic [15:0]       s_digits;

  int checks = 0;
  int errors = 0;

  always #5 iCLK = ~iCLK;

  frac_digit_sequencer #(.WIDTH_F(WF), .NDIG(NDIG), .IDXW(IDXW)) u_dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .i_start(i_start), .i_frac(i_frac),
    .o_busy(o_busy), .o_dig_valid(o_dig_valid), .i_dig_ready(i_dig_ready),
    .o_dig(o_dig), .o_dig_idx(o_dig_idx), .o_last(o_last),
    .o_digits(o_digits), .o_done(o_done), .o_carry(o_carry)
  );

  frac_digit_sequencer #(.WIDTH_F(WF), .NDIG(4), .IDXW(IDXW)) u_dut4 (
    .iCLK(iCLK), .iRST_N(iRST_N), .i_start(s_start), .i_frac(s_frac),
    .o_busy(s_busy), .o_dig_valid(s_valid), .i_dig_ready(1'b1),
    .o_dig(s_dig), .o_dig_idx(s_idx), .o_last(s_last),
    .o_digits(s_digits), .o_done(s_done), .o_carry(s_carry)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic start_run(input logic [WF-1:0] frac);
    i_frac  = frac;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_dig_valid && n < 60) begin
      tick();
      n++;
    end
    if (!o_dig_valid) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   o_busy,      0);
    check({tag, "_valid"},  o_dig_valid, 0);
    check({tag, "_dig"},    o_dig,       0);
    check({tag, "_idx"},    o_dig_idx,   0);
    check({tag, "_last"},   o_last,      0);
    check({tag, "_digits"}, o_digits,    0);
    check({tag, "_done"},   o_done,      0);
    check({tag, "_carry"},  o_carry,     0);
  endtask

  // Streams all digits with ready high, optionally holding ready low for
  // stall_n cycles in front of digit stall_idx. Returns in the o_done cycle.
  task automatic stream(input string tag, input logic [27:0] exp,
                        input int stall_idx, input int stall_n);
    logic [3:0] d;
    for (int i = 0; i < NDIG; i++) begin
      d = exp[4*(NDIG-1-i) +: 4];
      if (i == stall_idx) begin
        i_dig_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          check({tag, "_stall_dig"}, o_dig, d);
          check({tag, "_stall_idx"}, o_dig_idx, i);
          tick();
        end
      end
      check({tag, "_valid"}, o_dig_valid, 1);
      check({tag, "_dig"},   o_dig,       d);
      check({tag, "_idx"},   o_dig_idx,   i);
      check({tag, "_last"},  o_last,      (i == NDIG - 1));
      i_dig_ready = 1'b1;
      tick();
      i_dig_ready = 1'b0;
    end
    check({tag, "_done"},    o_done,      1);
    check({tag, "_busy"},    o_busy,      0);
    check({tag, "_valid_n"}, o_dig_valid, 0);
    check({tag, "_digits"},  o_digits,    exp);
  endtask

  initial begin
    int n;
    int last_seen;

    // Reset state
    repeat (2) tick();
    check_all_zero("rst");
    iRST_N = 1'b1;
    tick();
    check("rst_rel_busy", o_busy, 0);

    // 1: 0.5 -> 5000000, latency, one-cycle done
    start_run(15'h4000);
    check("t1_busy", o_busy, 1);
    wait_valid(n);
    check("t1_latency", n, LAT);
    stream("t1", 28'h5000000, -1, 0);
    tick();
    check("t1_done_1cyc", o_done, 0);

    // 2: max fraction
    start_run(15'h7FFF);
    wait_valid(n);
    check("t2_latency", n, LAT);
    stream("t2", EXP_MAX, -1, 0);
    check("t2_carry", o_carry, 0);
    tick();

    // 4: smallest fraction with a stall at idx 4
    start_run(15'h0001);
    wait_valid(n);
    stream("t4", 28'h0000305, 4, 3);
    tick();

    // 5: starts in CONV and EMIT are ignored; start in the done cycle is taken
    start_run(15'h4000);
    tick();
    i_frac  = 15'h7FFF;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("t5_conv_busy", o_busy, 1);
    wait_valid(n);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("t5_emit_idx", o_dig_idx, 0);
    check("t5_emit_dig", o_dig, 5);
    stream("t5a", 28'h5000000, -1, 0);
    start_run(15'h0001);
    check("t5_restart_busy", o_busy, 1);
    check("t5_restart_done", o_done, 0);
    wait_valid(n);
    stream("t5b", 28'h0000305, -1, 0);
    tick();

    // 6: async reset in EMIT at idx 2
    start_run(15'h4000);
    wait_valid(n);
    i_dig_ready = 1'b1;
    tick();
    tick();
    i_dig_ready = 1'b0;
    check("t6_idx", o_dig_idx, 2);
    #2;
    iRST_N = 1'b0;
    #1;
    check_all_zero("t6_async");
    tick();
    iRST_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_no_done", o_done, 0);
      check("t6_idle", o_busy, 0);
    end

    // 3: NDIG=4 instance, 0.9999|6
    s_frac  = 15'h7FFF;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n = 0;
    last_seen = 0;
    while (!s_done && n < 60) begin
      if (s_last) begin
        last_seen++;
        check("t3_last_idx", s_idx, 3);
      end
      tick();
      n++;
    end
    check("t3_done_seen", s_done, 1);
    check("t3_last_cnt", last_seen, 1);
    check("t3_digits", s_digits, EXP_S);
    check("t3_carry", s_carry, EXP_S_CY);
    check("t3_busy", s_busy, 0);
    check("t3_valid", s_valid, 0);
    check("t3_dig_idle", s_dig, EXP_S[15:12]);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
